mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a CPU port and a debug/loader port share a single
// fixed-latency memory. The CPU has priority, but the debug port is granted
// once it has waited through STARVE_MAX back-to-back CPU grants.
module mem_arbiter #(
   parameter int unsigned MEM_LAT    = 1,  // memory read latency, 1..3
   parameter int unsigned STARVE_MAX = 4   // CPU grants allowed while debug waits
) (
   input  logic        clk,
   input  logic        rst,
   // CPU port
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_adr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ready,
   // debug/loader port
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [31:0] dbg_adr,
   input  logic [31:0] dbg_wdata,
   output logic [31:0] dbg_rdata,
   output logic        dbg_ready,
   // memory side
   output logic [31:0] mem_adr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam logic [1:0] MemLat    = 2'(MEM_LAT);
   localparam logic [2:0] StarveMax = 3'(STARVE_MAX);

   typedef enum logic [1:0] {StIdle, StBusy, StCapt, StResp} state_e;

   state_e      state_q, state_d;
   logic        owner_q, owner_d;  // 1 = debug port owns the current access
   logic        we_q, we_d;
   logic [1:0]  lat_q, lat_d;
   logic [2:0]  starve_q, starve_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] cpu_rdata_q, cpu_rdata_d;
   logic [31:0] dbg_rdata_q, dbg_rdata_d;
   logic        grant_cpu, grant_dbg;

   // Arbitration decision, only acted on in StIdle.
   always_comb begin
      grant_dbg = dbg_req && (!cpu_req || (starve_q == StarveMax));
      grant_cpu = cpu_req && !grant_dbg;
   end

   // Next-state logic: access sequencing, latching and read capture.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      lat_d       = lat_q;
      starve_d    = starve_q;
      adr_d       = adr_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;
      unique case (state_q)
         StIdle: begin
            if (!dbg_req) begin
               starve_d = '0;
            end
            if (grant_dbg) begin
               state_d  = StBusy;
               owner_d  = 1'b1;
               we_d     = dbg_we;
               adr_d    = dbg_adr;
               wdata_d  = dbg_wdata;
               lat_d    = MemLat;
               starve_d = '0;
            end else if (grant_cpu) begin
               state_d = StBusy;
               owner_d = 1'b0;
               we_d    = cpu_we;
               adr_d   = cpu_adr;
               wdata_d = cpu_wdata;
               lat_d   = MemLat;
               // Only CPU grants that overtake a waiting debug request count.
               if (dbg_req && (starve_q != 3'd7)) begin
                  starve_d = starve_q + 3'd1;
               end
            end
         end
         StBusy: begin
            lat_d = lat_q - 2'd1;
            if (lat_q == 2'd1) begin
               state_d = StCapt;
            end
         end
         StCapt: begin
            if (!we_q) begin
               if (owner_q) begin
                  dbg_rdata_d = mem_rdata;
               end else begin
                  cpu_rdata_d = mem_rdata;
               end
            end
            state_d = StResp;
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         lat_q       <= '0;
         starve_q    <= '0;
         adr_q       <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         lat_q       <= lat_d;
         starve_q    <= starve_d;
         adr_q       <= adr_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   // Outputs decoded from registered state only.
   always_comb begin
      busy      = (state_q != StIdle);
      // lat_q still holds its load value only in the first BUSY cycle.
      mem_we    = (state_q == StBusy) && we_q && (lat_q == MemLat);
      cpu_ready = (state_q == StResp) && !owner_q;
      dbg_ready = (state_q == StResp) && owner_q;
      mem_adr   = adr_q;
      mem_wdata = wdata_q;
      cpu_rdata = cpu_rdata_q;
      dbg_rdata = dbg_rdata_q;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MEM_LAT=1 and one with
// MEM_LAT=3 share the stimulus; each has its own memory data model.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [31:0] cpu_adr, cpu_wdata, dbg_adr, dbg_wdata;

   logic [31:0] d1_cpu_rdata, d1_dbg_rdata, d1_mem_adr, d1_mem_wdata, d1_mem_rdata;
   logic        d1_cpu_ready, d1_dbg_ready, d1_mem_we, d1_busy;
   logic [31:0] d3_cpu_rdata, d3_dbg_rdata, d3_mem_adr, d3_mem_wdata, d3_mem_rdata;
   logic        d3_cpu_ready, d3_dbg_ready, d3_mem_we, d3_busy;

   int          n_total = 0;
   int          n_bad   = 0;
   int          cyc     = 0;
   int          rd_cyc1 = -1;
   int          rd_cyc3 = -1;
   logic [31:0] rd_val1 = '0;
   logic [31:0] rd_val3 = '0;
   logic [1:0]  seq [10];
   int          n_seen;
   int          n_evt;
   int          t0;

   // Memory returns valid data only in the single cycle the bench schedules.
   assign d1_mem_rdata = (cyc == rd_cyc1) ? rd_val1 : 32'hBAD0_BAD0;
   assign d3_mem_rdata = (cyc == rd_cyc3) ? rd_val3 : 32'hBAD0_BAD0;

   mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(d1_cpu_rdata), .cpu_ready(d1_cpu_ready),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(d1_dbg_rdata), .dbg_ready(d1_dbg_ready),
      .mem_adr(d1_mem_adr), .mem_we(d1_mem_we), .mem_wdata(d1_mem_wdata),
      .mem_rdata(d1_mem_rdata), .busy(d1_busy)
   );

   mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(d3_cpu_rdata), .cpu_ready(d3_cpu_ready),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(d3_dbg_rdata), .dbg_ready(d3_dbg_ready),
      .mem_adr(d3_mem_adr), .mem_we(d3_mem_we), .mem_wdata(d3_mem_wdata),
      .mem_rdata(d3_mem_rdata), .busy(d3_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle number, constant between rising edges.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_adr = '0; dbg_wdata = '0;
      step();
      step();
      check_eq("rst_busy", d1_busy, 1'b0);
      check_eq("rst_cpu_ready", d1_cpu_ready, 1'b0);
      check_eq("rst_dbg_ready", d1_dbg_ready, 1'b0);
      check_eq("rst_mem_we", d1_mem_we, 1'b0);
      check_eq("rst_mem_adr", d1_mem_adr, 32'h0);
      check_eq("rst_mem_wdata", d1_mem_wdata, 32'h0);
      check_eq("rst_cpu_rdata", d1_cpu_rdata, 32'h0);
      check_eq("rst_dbg_rdata", d1_dbg_rdata, 32'h0);
      rst = 1'b1;
      step();

      // CPU read, MEM_LAT=1: capture in T+2, ready in T+3.
      t0 = cyc;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h0000_0010;
      rd_cyc1 = t0 + 2; rd_val1 = 32'hDEAD_BEEF;
      step();
      check_eq("rd_t1_busy", d1_busy, 1'b1);
      check_eq("rd_t1_adr", d1_mem_adr, 32'h10);
      check_eq("rd_t1_we", d1_mem_we, 1'b0);
      check_eq("rd_t1_ready", d1_cpu_ready, 1'b0);
      cpu_req = 1'b0;
      step();
      check_eq("rd_t2_adr", d1_mem_adr, 32'h10);
      check_eq("rd_t2_ready", d1_cpu_ready, 1'b0);
      step();
      check_eq("rd_t3_ready", d1_cpu_ready, 1'b1);
      check_eq("rd_t3_dbg_ready", d1_dbg_ready, 1'b0);
      check_eq("rd_t3_rdata", d1_cpu_rdata, 32'hDEAD_BEEF);
      check_eq("rd_t3_dbg_rdata", d1_dbg_rdata, 32'h0);
      step();
      check_eq("rd_t4_ready", d1_cpu_ready, 1'b0);
      check_eq("rd_t4_busy", d1_busy, 1'b0);
      check_eq("rd_t4_adr_hold", d1_mem_adr, 32'h10);
      rd_cyc1 = -1;

      // Debug write: mem_we only in T+1, no rdata change.
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_adr = 32'h0000_0040; dbg_wdata = 32'h1234_5678;
      step();
      check_eq("wr_t1_we", d1_mem_we, 1'b1);
      check_eq("wr_t1_adr", d1_mem_adr, 32'h40);
      check_eq("wr_t1_wdata", d1_mem_wdata, 32'h1234_5678);
      dbg_req = 1'b0;
      step();
      check_eq("wr_t2_we", d1_mem_we, 1'b0);
      check_eq("wr_t2_wdata", d1_mem_wdata, 32'h1234_5678);
      step();
      check_eq("wr_t3_dbg_ready", d1_dbg_ready, 1'b1);
      check_eq("wr_t3_cpu_ready", d1_cpu_ready, 1'b0);
      check_eq("wr_t3_we", d1_mem_we, 1'b0);
      check_eq("wr_t3_dbg_rdata", d1_dbg_rdata, 32'h0);
      check_eq("wr_t3_cpu_rdata", d1_cpu_rdata, 32'hDEAD_BEEF);
      step();

      // Debug read loads only the debug rdata register.
      t0 = cyc;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 32'h0000_0080;
      rd_cyc1 = t0 + 2; rd_val1 = 32'hCAFE_F00D;
      step();
      dbg_req = 1'b0;
      step();
      step();
      check_eq("drd_t3_ready", d1_dbg_ready, 1'b1);
      check_eq("drd_t3_rdata", d1_dbg_rdata, 32'hCAFE_F00D);
      check_eq("drd_t3_cpu_rdata", d1_cpu_rdata, 32'hDEAD_BEEF);
      step();
      rd_cyc1 = -1;

      // Both requesting continuously: CPU x4 then DBG, repeating.
      cpu_req = 1'b1; cpu_we = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0;
      n_seen = 0;
      for (int i = 0; i < 60 && n_seen < 10; i++) begin
         step();
         if (d1_cpu_ready || d1_dbg_ready) begin
            seq[n_seen] = {d1_cpu_ready, d1_dbg_ready};
            n_seen++;
         end
      end
      cpu_req = 1'b0; dbg_req = 1'b0;
      check_eq("starve_count", n_seen, 10);
      for (int k = 0; k < 10; k++) begin
         check_eq($sformatf("starve_grant%0d", k), seq[k], (k % 5 == 4) ? 2'b01 : 2'b10);
      end
      step();
      step();

      // Simultaneous requests in the first cycle out of reset.
      rst = 1'b0;
      step();
      check_eq("rst2_busy", d1_busy, 1'b0);
      rst = 1'b1; cpu_req = 1'b1; dbg_req = 1'b1; cpu_we = 1'b0; dbg_we = 1'b0;
      step();
      cpu_req = 1'b0;
      step();
      step();
      check_eq("sim_r3_cpu_ready", d1_cpu_ready, 1'b1);
      check_eq("sim_r3_dbg_ready", d1_dbg_ready, 1'b0);
      step();
      check_eq("sim_r4_busy", d1_busy, 1'b0);
      step();
      dbg_req = 1'b0;
      step();
      step();
      check_eq("sim_r7_dbg_ready", d1_dbg_ready, 1'b1);
      check_eq("sim_r7_cpu_ready", d1_cpu_ready, 1'b0);
      step();

      // MEM_LAT=3 write aborted by reset during BUSY.
      rst = 1'b0;
      step();
      rst = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h0000_0100; cpu_wdata = 32'hA5A5_A5A5;
      step();
      check_eq("abt_t1_we", d3_mem_we, 1'b1);
      check_eq("abt_t1_busy", d3_busy, 1'b1);
      check_eq("abt_t1_adr", d3_mem_adr, 32'h100);
      cpu_req = 1'b0;
      step();
      check_eq("abt_t2_we", d3_mem_we, 1'b0);
      check_eq("abt_t2_busy", d3_busy, 1'b1);
      rst = 1'b0;
      step();
      check_eq("abt_busy", d3_busy, 1'b0);
      check_eq("abt_we", d3_mem_we, 1'b0);
      check_eq("abt_cpu_rdata", d3_cpu_rdata, 32'h0);
      check_eq("abt_dbg_rdata", d3_dbg_rdata, 32'h0);
      check_eq("abt_mem_adr", d3_mem_adr, 32'h0);
      rst = 1'b1;
      n_evt = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (d3_cpu_ready || d3_dbg_ready || d3_mem_we || d3_busy) n_evt++;
      end
      check_eq("abt_quiet", n_evt, 0);

      // MEM_LAT=3 read: ready in T+5, request dropped during BUSY.
      t0 = cyc;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h0000_0200;
      rd_cyc3 = t0 + 4; rd_val3 = 32'h5EED_1234;
      for (int k = 1; k <= 4; k++) begin
         step();
         check_eq($sformatf("l3_t%0d_adr", k), d3_mem_adr, 32'h200);
         check_eq($sformatf("l3_t%0d_ready", k), d3_cpu_ready, 1'b0);
         check_eq($sformatf("l3_t%0d_we", k), d3_mem_we, 1'b0);
         if (k == 1) cpu_req = 1'b0;
      end
      step();
      check_eq("l3_t5_ready", d3_cpu_ready, 1'b1);
      check_eq("l3_t5_rdata", d3_cpu_rdata, 32'h5EED_1234);
      check_eq("l3_t5_dbg_rdata", d3_dbg_rdata, 32'h0);
      step();
      check_eq("l3_t6_ready", d3_cpu_ready, 1'b0);
      check_eq("l3_t6_busy", d3_busy, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
